// File: rtl/string_decrypt_control.sv
// Decrypts the 16-entry string memory in place: c[i] ^= (key + i), stopping at a raw 0x00
// terminator or after 16 bytes. Three cycles per byte: present address, read/write, advance.
module string_decrypt_control (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] key,
  input  logic [7:0] mem_rdata,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       busy,
  output logic       done,
  output logic [4:0] count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StRead = 3'd2;
  localparam logic [2:0] StInc  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [7:0] key_q, key_d;
  logic [7:0] plain;
  logic       in_read;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = 5'd0;
          key_d   = key;
          state_d = StAddr;
        end
      end
      StAddr:  state_d = idx_q[4] ? StDone : StRead;
      // Only a raw 0x00 ends the pass; a decrypted 0x00 is an ordinary byte.
      StRead:  state_d = (mem_rdata == 8'h00) ? StDone : StInc;
      StInc: begin
        idx_d   = idx_q + 5'd1;
        state_d = StAddr;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 5'd0;
      key_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
    end
  end

  assign plain   = mem_rdata ^ (key_q + {4'b0000, idx_q[3:0]});
  assign in_read = (state_q == StRead) && reset;

  // Write path is gated by reset so an aborted READ cycle never commits.
  assign mem_addr  = idx_q[3:0];
  assign mem_we    = in_read && (mem_rdata != 8'h00);
  assign mem_wdata = in_read ? plain : 8'h00;
  assign busy      = (state_q == StAddr) || (state_q == StRead) || (state_q == StInc);
  assign done      = (state_q == StDone);
  assign count     = idx_q;

endmodule

// File: tb/tb_string_decrypt_control.sv
// Bench for string_decrypt_control: behavioural sync-read memory, table of passes with a
// write scoreboard, and hand-written reset / start-handling sequences.
module tb_string_decrypt_control;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [7:0] key, mem_rdata;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, busy, done;
  logic [4:0] count;

  always #5 clock = ~clock;

  string_decrypt_control dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .key       (key),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  logic [7:0]   mem [16];
  logic         load_req;
  logic [127:0] load_img;

  always @(posedge clock) begin
    if (load_req) begin
      for (int j = 0; j < 16; j++) mem[j] <= load_img[j*8 +: 8];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] cyc;
  } wr_t;

  typedef struct {
    string        name;
    logic [7:0]   key;
    logic [127:0] img;
    int           exp_count;
    int           exp_done;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [127:0] img);
    @(negedge clock);
    load_img = img;
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({name, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({name, " mem_we"}, 32'(mem_we), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " done"}, 32'(done), 32'd0);
    check({name, " count"}, 32'(count), 32'd0);
  endtask

  // Runs one pass over the current memory; expected writes come from a model of the cipher.
  task automatic run_pass(input string name, input logic [7:0] k, input int exp_count,
                          input int exp_done, input bit disturb);
    logic [7:0] exp_mem [16];
    wr_t        w;
    int         done_cyc;
    bit         busy_bad;
    sb.delete();
    for (int j = 0; j < 16; j++) exp_mem[j] = mem[j];
    for (int j = 0; j < 16; j++) begin
      if (mem[j] == 8'h00) break;
      w.addr = 4'(j);
      w.data = mem[j] ^ (k + 8'(j));
      w.cyc  = 8'(3 * j + 2);
      sb.push_back(w);
      exp_mem[j] = w.data;
    end
    @(negedge clock);
    start = 1'b1;
    key   = k;
    @(posedge clock);
    #1 start = 1'b0;
    done_cyc = -1;
    busy_bad = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clock);
      if (mem_we) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s unexpected write: addr %0h data %0h cycle %0d, expected none",
                   name, mem_addr, mem_wdata, cyc);
        end else begin
          w = sb.pop_front();
          check({name, " write addr"}, 32'(mem_addr), 32'(w.addr));
          check({name, " write data"}, 32'(mem_wdata), 32'(w.data));
          check({name, " write cycle"}, 32'(cyc), 32'(w.cyc));
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (disturb && cyc == 4) begin
        start = 1'b1;
        key   = ~k;
      end
      if (disturb && cyc == 6) start = 1'b0;
    end
    key = k;
    check({name, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, " count"}, 32'(count), 32'(exp_count));
    check({name, " busy low in done"}, 32'(busy), 32'd0);
    check({name, " busy during pass"}, 32'(busy_bad), 32'd0);
    check({name, " missing writes"}, 32'(sb.size()), 32'd0);
    @(negedge clock);
    check({name, " done one cycle"}, 32'(done), 32'd0);
    check({name, " count held"}, 32'(count), 32'(exp_count));
    for (int j = 0; j < 16; j++) check($sformatf("%s mem[%0d]", name, j), 32'(mem[j]),
                                       32'(exp_mem[j]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] orig [16];
    logic [127:0] img;
    int   done_cyc;
    bit   we_seen;
    reset    = 1'b0;
    start    = 1'b0;
    key      = 8'h00;
    load_req = 1'b0;
    load_img = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock);
    #1 reset = 1'b1;

    vecs[0] = '{"short", 8'h10, '0, 2, 9};
    vecs[0].img[7:0]   = 8'h58;
    vecs[0].img[15:8]  = 8'h74;
    vecs[1] = '{"empty", 8'hA7, {16{8'h5A}}, 0, 3};
    vecs[1].img[7:0]   = 8'h00;
    vecs[2] = '{"term15", 8'h3B, {16{8'h99}}, 15, 48};
    vecs[2].img[127:120] = 8'h00;
    vecs[3] = '{"full", 8'hF5, '0, 16, 50};
    for (int j = 0; j < 16; j++) vecs[3].img[j*8 +: 8] = 8'h80 | 8'(j);
    vecs[3].img[11*8 +: 8] = 8'h3C;
    vecs[3].img[15*8 +: 8] = 8'h04;

    for (int v = 0; v < 4; v++) begin
      load(vecs[v].img);
      run_pass(vecs[v].name, vecs[v].key, vecs[v].exp_count, vecs[v].exp_done, 1'b0);
    end
    check("full key wrap mem[11]", 32'(mem[11]), 32'h3C);
    check("full zero plain mem[15]", 32'(mem[15]), 32'h00);

    // Round trip: encrypt "Hi!" with key 0x42, then decrypt.
    img = '0;
    img[7:0]   = 8'h48 ^ 8'h42;
    img[15:8]  = 8'h69 ^ 8'h43;
    img[23:16] = 8'h21 ^ 8'h44;
    load(img);
    run_pass("roundtrip", 8'h42, 3, 12, 1'b0);
    check("roundtrip H", 32'(mem[0]), 32'h48);
    check("roundtrip i", 32'(mem[1]), 32'h69);
    check("roundtrip !", 32'(mem[2]), 32'h21);
    check("roundtrip nul", 32'(mem[3]), 32'h00);

    // Start pulsed and key changed mid-pass must not disturb the pass.
    load(vecs[0].img);
    run_pass("disturb", 8'h10, 2, 9, 1'b1);
    check("disturb mem[0]", 32'(mem[0]), 32'h48);
    check("disturb mem[1]", 32'(mem[1]), 32'h65);

    // Back-to-back passes with start held high over an empty string.
    load('0);
    @(negedge clock);
    start    = 1'b1;
    key      = 8'h33;
    done_cyc = -1;
    we_seen  = 1'b0;
    @(posedge clock);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock);
      if (mem_we) we_seen = 1'b1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check("b2b first done cycle", 32'(done_cyc), 32'd3);
    @(negedge clock);
    check("b2b idle busy", 32'(busy), 32'd0);
    check("b2b idle done", 32'(done), 32'd0);
    @(negedge clock);
    check("b2b second addr busy", 32'(busy), 32'd1);
    check("b2b second addr count", 32'(count), 32'd0);
    start = 1'b0;
    @(negedge clock);
    if (mem_we) we_seen = 1'b1;
    @(negedge clock);
    check("b2b second done", 32'(done), 32'd1);
    check("b2b no writes", 32'(we_seen), 32'd0);

    // Reset asserted during the READ of byte 3.
    img = '0;
    for (int j = 0; j < 6; j++) img[j*8 +: 8] = 8'h31 + 8'(j);
    load(img);
    for (int j = 0; j < 16; j++) orig[j] = mem[j];
    @(negedge clock);
    start = 1'b1;
    key   = 8'h20;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort write suppressed", 32'(mem_we), 32'd0);
    check("abort wdata forced", 32'(mem_wdata), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("after abort");
    check("abort mem[3] kept", 32'(mem[3]), 32'(orig[3]));
    for (int j = 0; j < 3; j++)
      check($sformatf("abort mem[%0d] decrypted", j), 32'(mem[j]), 32'(orig[j] ^ (8'h20 + 8'(j))));
    run_pass("rerun", 8'h20, 6, 21, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/string_decrypt_control.md
# string_decrypt_control

Decryption engine for the 16-entry, 8-bit string memory; the inverse of the string encryption controller. On `start` it walks memory from address 0 and replaces each ciphertext byte `c[i]` with `c[i] XOR (key + i)`. It stops at a stored 0x00 terminator or after 16 entries, then pulses `done`. The block sits beside the encryption controller, shares the same external synchronous-read memory, and drives that memory only while busy.

## Interface
- No parameters. Depth is fixed at 16 entries and data width at 8 bits.
- `clock` input 1: single clock; all state changes occur on its rising edge.
- `reset` input 1: synchronous, active-low. When 0 at a rising edge, the block returns to IDLE.
- `start` input 1: level sampled in IDLE. A 1 begins a decrypt pass. Ignored in every other state.
- `key` input 8: base key. Latched into an internal register when `start` is accepted.
- `mem_rdata` input 8: memory read data. Valid the cycle after `mem_addr` is presented (synchronous read).
- `mem_addr` output 4: memory address, equal to `i[3:0]`.
- `mem_wdata` output 8: `mem_rdata XOR (key_r + i[3:0])`, mod 256.
- `mem_we` output 1: memory write enable. The write commits at the rising edge ending the cycle in which `mem_we` is high.
- `busy` output 1: high in ADDR, READ and INC.
- `done` output 1: one-cycle pulse in the DONE state.
- `count` output 5: bytes decrypted in the current or last pass (the internal index `i`). Range 0..16.

## Operation
- Internal registers:
  - `state`
  - `i[4:0]`
  - `key_r[7:0]`
- States and transitions:
  - IDLE: if `start`=1, then `i`<=0, `key_r`<=`key`, go to ADDR. Otherwise stay in IDLE.
  - ADDR: if `i`==16, go to DONE. Otherwise `mem_addr`=`i`, go to READ.
  - READ: `mem_rdata` holds `mem[i]`.
    - If `mem_rdata`==0x00, go to DONE. There is no write; the terminator is stored in clear and stays 0x00.
    - Otherwise `mem_we`=1 with `mem_wdata` as defined above, then go to INC.
  - INC: `i`<=`i`+1, go to ADDR.
  - DONE: `done`=1 for this cycle, go to IDLE. `count` holds its value until the next accepted `start`.
- Arithmetic: `key_r + i[3:0]` is an 8-bit sum that wraps mod 256. Example: key 0xF5, i=11 gives 0x00.
- A decrypted value of 0x00 (ciphertext equal to `key_r + i`) is written normally and does not terminate the pass. Only a raw 0x00 in memory terminates.
- `key` changes after acceptance have no effect until the next pass.
- `start` held high across DONE starts a new pass from IDLE on the following cycle.
- Reset mid-pass: the block aborts at the reset edge.
  - Memory keeps any bytes already written; a partially decrypted string is accepted.
  - A write in progress in the reset cycle is suppressed: `mem_we` is forced to 0 while `reset`=0.
- Outputs must never drive X while `reset` is deasserted.

## Timing
- Reset values (state IDLE): `mem_addr`=0, `mem_wdata`=0 (forced), `mem_we`=0, `busy`=0, `done`=0, `count`=0.
- Let cycle 0 be the IDLE cycle in which `start`=1 is sampled.
  - Byte `j` occupies cycles ADDR=3j+1, READ=3j+2, INC=3j+3.
- Terminator at index k (0 ≤ k ≤ 15):
  - READ sees 0x00 in cycle 3k+2.
  - `done` is high in cycle 3k+3.
  - `count`=k.
- No terminator:
  - ADDR with `i`=16 occurs in cycle 49.
  - `done` is high in cycle 50.
  - `count`=16.
- Throughput is 3 cycles per byte. At most one memory write per 3 cycles, always in READ.
- `busy` is high from cycle 1 through the last ADDR/READ cycle and low in DONE.

## Test plan
- Short string: key 0x10; mem[0]=0x58, mem[1]=0x74, mem[2]=0x00; start at cycle 0.
  - Writes: mem[0]=0x48 in cycle 2, mem[1]=0x65 in cycle 5.
  - `done` high in cycle 9 only; `count`=2; mem[2] stays 0x00.
- Empty string: mem[0]=0x00, any key.
  - No `mem_we` pulse at any point.
  - `done` high in cycle 3; `count`=0.
- Full length with key wrap: key 0xF5, all 16 bytes nonzero; mem[11]=0x3C, mem[15]=0x04.
  - mem[11] becomes 0x3C (key+11 = 0x00).
  - mem[15] becomes 0x00, and decryption does not stop there.
  - `done` high in cycle 50; `count`=16.
- Round trip: encrypt the string "Hi!" with key 0x42 using the encryption controller, then run this block with key 0x42.
  - Memory reads 0x48, 0x69, 0x21, 0x00.
- Reset mid-pass: assert `reset`=0 during the READ of byte 3.
  - mem[3] is unchanged; mem[0..2] are decrypted.
  - All outputs show reset values on the next cycle.
  - A new start re-runs from i=0.
- Start/key handling:
  - `start` pulsed while busy has no effect.
  - Changing `key` mid-pass does not alter written values.
  - `start` held high gives back-to-back passes: a new ADDR follows exactly 2 cycles after DONE (DONE, then IDLE, then ADDR).
